// File: rtl/surf_cmd_tx.sv
// Serial CMD-line transmitter: latches a command word on a valid/ready handshake and shifts it out
// as start/data/parity/stop bits followed by a low gap. Optional parity bit: SURF_CMD_TX_PARITY_EN.
module surf_cmd_tx #(
  parameter int unsigned CMD_WIDTH    = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned GAP_CYCLES   = 4
) (
  input  logic                 clk33_i,
  input  logic                 rst_i,
  input  logic [CMD_WIDTH-1:0] cmd_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  output logic                 CMD_o,
  output logic                 busy_o,
  output logic [15:0]          frame_count_o
);

  localparam int unsigned CntW = $clog2(CLKS_PER_BIT + 1);
  localparam int unsigned IdxW = (CMD_WIDTH > 1) ? $clog2(CMD_WIDTH) : 1;
  localparam int unsigned GapW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  localparam logic [CntW-1:0] BitLast = CntW'(CLKS_PER_BIT - 1);
  localparam logic [IdxW-1:0] IdxMsb  = IdxW'(CMD_WIDTH - 1);
  localparam logic [GapW-1:0] GapLast = GapW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);

  typedef enum logic [2:0] {
    StIdle,
    StStart,
    StData,
    StStop,
    StGap
`ifdef SURF_CMD_TX_PARITY_EN
    , StParity
`endif
  } state_e;

  state_e               state_q, state_d;
  logic [CntW-1:0]      cnt_q, cnt_d;
  logic [IdxW-1:0]      idx_q, idx_d;
  logic [GapW-1:0]      gap_q, gap_d;
  logic [CMD_WIDTH-1:0] shift_q, shift_d;
  logic                 line_q, line_d;
  logic [15:0]          count_q, count_d;
  logic                 bit_end;
`ifdef SURF_CMD_TX_PARITY_EN
  logic                 par_q, par_d;
`endif

  assign bit_end = (cnt_q == BitLast);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    gap_d   = gap_q;
    shift_d = shift_q;
    count_d = count_q;
`ifdef SURF_CMD_TX_PARITY_EN
    par_d   = par_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (cmd_valid_i) begin
          state_d = StStart;
          cnt_d   = '0;
          idx_d   = IdxMsb;
          shift_d = cmd_i;
          count_d = count_q + 16'd1;
`ifdef SURF_CMD_TX_PARITY_EN
          par_d   = ~^cmd_i;
`endif
        end
      end
      StStart: begin
        if (bit_end) begin
          state_d = StData;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StData: begin
        if (bit_end) begin
          cnt_d = '0;
          if (idx_q == '0) begin
`ifdef SURF_CMD_TX_PARITY_EN
            state_d = StParity;
`else
            state_d = StStop;
`endif
          end else begin
            // Line always shows the MSB of the shift register.
            idx_d   = idx_q - IdxW'(1);
            shift_d = shift_q << 1;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`ifdef SURF_CMD_TX_PARITY_EN
      StParity: begin
        if (bit_end) begin
          state_d = StStop;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
`endif
      StStop: begin
        if (bit_end) begin
          cnt_d = '0;
          gap_d = '0;
          if (GAP_CYCLES == 0) begin
            state_d = StIdle;
          end else begin
            state_d = StGap;
          end
        end else begin
          cnt_d = cnt_q + CntW'(1);
        end
      end
      StGap: begin
        if (gap_q == GapLast) begin
          state_d = StIdle;
        end else begin
          gap_d = gap_q + GapW'(1);
        end
      end
      default: state_d = StIdle;
    endcase

    // Line level follows the next state so CMD_o is a plain flop aligned with the FSM.
    line_d = 1'b0;
    case (state_d)
      StStart:  line_d = 1'b1;
      StData:   line_d = shift_d[CMD_WIDTH-1];
`ifdef SURF_CMD_TX_PARITY_EN
      StParity: line_d = par_d;
`endif
      default:  line_d = 1'b0;
    endcase
  end

  always_ff @(posedge clk33_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= StIdle;
      cnt_q   <= '0;
      idx_q   <= '0;
      gap_q   <= '0;
      shift_q <= '0;
      line_q  <= 1'b0;
      count_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      gap_q   <= gap_d;
      shift_q <= shift_d;
      line_q  <= line_d;
      count_q <= count_d;
    end
  end

`ifdef SURF_CMD_TX_PARITY_EN
  always_ff @(posedge clk33_i or posedge rst_i) begin
    if (rst_i) begin
      par_q <= 1'b0;
    end else begin
      par_q <= par_d;
    end
  end
`endif

  assign cmd_ready_o   = (state_q == StIdle);
  assign busy_o        = ~cmd_ready_o;
  assign CMD_o         = line_q;
  assign frame_count_o = count_q;

endmodule

// File: tb/tb_surf_cmd_tx.sv
// Scoreboard bench for surf_cmd_tx: per-cycle expected line/ready values are queued on acceptance
// and compared on the falling clock edge.
module tb_surf_cmd_tx;

  localparam int W   = 8;
  localparam int CPB = 4;
  localparam int GAP = 4;
`ifdef SURF_CMD_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int FRAME = (W + 2 + P) * CPB + GAP;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] cmd = '0;
  logic         cmd_valid = 1'b0;
  logic         cmd_ready;
  logic         cmd_line;
  logic         busy;
  logic [15:0]  frame_count;

  typedef struct packed {
    logic line;
    logic ready;
  } exp_t;

  exp_t exp_q[$];
  exp_t mon_e;
  int   total = 0;
  int   bad   = 0;

  surf_cmd_tx #(
    .CMD_WIDTH   (W),
    .CLKS_PER_BIT(CPB),
    .GAP_CYCLES  (GAP)
  ) dut (
    .clk33_i      (clk),
    .rst_i        (rst),
    .cmd_i        (cmd),
    .cmd_valid_i  (cmd_valid),
    .cmd_ready_o  (cmd_ready),
    .CMD_o        (cmd_line),
    .busy_o       (busy),
    .frame_count_o(frame_count)
  );

  always #5 clk = ~clk;

  // Scoreboard: one queued entry per clock cycle while a frame is expected.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      mon_e = exp_q.pop_front();
      total++;
      if (cmd_line !== mon_e.line || cmd_ready !== mon_e.ready || busy !== ~mon_e.ready) begin
        bad++;
        $display("FAIL line_cycle t=%0t: CMD=%b ready=%b busy=%b, expected CMD=%b ready=%b busy=%b",
                 $time, cmd_line, cmd_ready, busy, mon_e.line, mon_e.ready, ~mon_e.ready);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running at t=%0t, expected finish", $time);
    $fatal(1, "timeout");
  end

  task automatic push_frame(input logic [W-1:0] d);
    exp_t e;
    e.ready = 1'b0;
    e.line  = 1'b1;
    repeat (CPB) exp_q.push_back(e);
    for (int i = W - 1; i >= 0; i--) begin
      e.line = d[i];
      repeat (CPB) exp_q.push_back(e);
    end
    if (P == 1) begin
      e.line = ~^d;
      repeat (CPB) exp_q.push_back(e);
    end
    e.line = 1'b0;
    repeat (CPB + GAP) exp_q.push_back(e);
    e.ready = 1'b1;
    exp_q.push_back(e);
  endtask

  // Returns at the falling edge of the first cycle after the acceptance edge.
  task automatic accept(input logic [W-1:0] d, input bit hold);
    @(negedge clk);
    total++;
    if (cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL ready_before_accept: cmd_ready=%b, expected 1", cmd_ready);
    end
    cmd       = d;
    cmd_valid = 1'b1;
    @(posedge clk);
    push_frame(d);
    @(negedge clk);
    if (!hold) cmd_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() > 0 && n < 500) begin
      @(negedge clk);
      n++;
    end
    total++;
    if (exp_q.size() > 0) begin
      bad++;
      $display("FAIL drain_timeout: %0d entries left, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic check_count(input string name, input logic [15:0] exp_cnt);
    total++;
    if (frame_count !== exp_cnt) begin
      bad++;
      $display("FAIL %s: frame_count=%h, expected %h", name, frame_count, exp_cnt);
    end
  endtask

  task automatic test_reset();
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    total++;
    if (cmd_line !== 1'b0) begin
      bad++;
      $display("FAIL reset_cmd: CMD=%b, expected 0", cmd_line);
    end
    total++;
    if (cmd_ready !== 1'b1 || busy !== 1'b0) begin
      bad++;
      $display("FAIL reset_ready: ready=%b busy=%b, expected 1/0", cmd_ready, busy);
    end
    check_count("reset_count", 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_send_a5();
    int n = 0;
    accept(8'hA5, 1'b0);
    check_count("a5_count", 16'd1);
    while (cmd_ready === 1'b0 && n < 200) begin
      n++;
      @(negedge clk);
    end
    total++;
    if (n != FRAME) begin
      bad++;
      $display("FAIL a5_busy_cycles: ready low %0d cycles, expected %0d", n, FRAME);
    end
    wait_drain();
  endtask

  task automatic test_parity();
    logic [W-1:0] vals [3];
    logic         pbit [3];
    vals[0] = 8'h01; pbit[0] = 1'b0;
    vals[1] = 8'h00; pbit[1] = 1'b1;
    vals[2] = 8'hFF; pbit[2] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      accept(vals[i], 1'b0);
`ifdef SURF_CMD_TX_PARITY_EN
      // Land in the second cycle of the parity bit.
      repeat ((W + 1) * CPB + 1) @(negedge clk);
      total++;
      if (cmd_line !== pbit[i]) begin
        bad++;
        $display("FAIL parity_%h: CMD=%b, expected %b", vals[i], cmd_line, pbit[i]);
      end
`endif
      wait_drain();
    end
    check_count("parity_count", 16'd4);
  endtask

  task automatic test_back_to_back();
    int  c = 1;
    bit  seen_ready = 1'b0;
    bit  found = 1'b0;
    accept(8'h3C, 1'b1);
    cmd = 8'hC3;
    push_frame(8'hC3);
    while (!found && c < 200) begin
      @(negedge clk);
      c++;
      if (cmd_ready === 1'b1) seen_ready = 1'b1;
      else if (seen_ready && cmd_line === 1'b1) found = 1'b1;
    end
    cmd_valid = 1'b0;
    total++;
    if (!found || (c - 1) != FRAME + 1) begin
      bad++;
      $display("FAIL b2b_start_spacing: found=%0d spacing=%0d, expected %0d", found, c - 1, FRAME + 1);
    end
    wait_drain();
    check_count("b2b_count", 16'd6);
  endtask

  task automatic test_reset_mid_frame();
    accept(8'hA5, 1'b0);
    // Move into data bit 3.
    repeat (4 * CPB + 1) @(negedge clk);
    check_count("mid_count_before", 16'd7);
    @(posedge clk);
    #2;
    exp_q.delete();
    rst = 1'b1;
    #1;
    total++;
    if (cmd_line !== 1'b0 || cmd_ready !== 1'b1) begin
      bad++;
      $display("FAIL mid_reset_outputs: CMD=%b ready=%b, expected 0/1", cmd_line, cmd_ready);
    end
    check_count("mid_reset_count", 16'h0000);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    accept(8'h5A, 1'b0);
    wait_drain();
    check_count("mid_after_count", 16'd1);
  endtask

  task automatic test_wrap();
    @(negedge clk);
    force dut.count_q = 16'hFFFF;
    #1;
    check_count("wrap_preload", 16'hFFFF);
    release dut.count_q;
    accept(8'h81, 1'b0);
    check_count("wrap_count", 16'h0000);
    wait_drain();
  endtask

  initial begin
    #1 rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    test_reset();
    test_send_a5();
    test_parity();
    test_back_to_back();
    test_reset_mid_frame();
    test_wrap();
    repeat (5) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/surf_cmd_tx.md
# surf_cmd_tx

Serial command transmitter that drives the CMD line received by the SURF board-level infrastructure. It lives on the trigger/controller side (or in a loopback test fixture) and runs in the 33 MHz local-bus clock domain. A parallel command word is accepted over a valid/ready handshake and shifted out as a framed serial bit stream. The single-ended output feeds an external OBUFDS pair to CMD_P/CMD_N.

## Interface
Parameters:
- CMD_WIDTH, 8, command word width in bits (>= 1).
- CLKS_PER_BIT, 4, clk33_i cycles per serial bit (>= 1).
- GAP_CYCLES, 4, idle-low cycles forced after each stop bit (>= 0; 0 means no gap).

Ports:
- clk33_i  in  1  33 MHz clock; the only clock.
- rst_i  in  1  reset, asynchronous, active-high.
- cmd_i  in  CMD_WIDTH  command word; sampled only on acceptance.
- cmd_valid_i  in  1  command word offered.
- cmd_ready_o  out  1  transmitter idle, can accept a word.
- CMD_o  out  1  serial line, registered; to OBUFDS.
- busy_o  out  1  frame or gap in progress (= ~cmd_ready_o).
- frame_count_o  out  16  count of accepted commands; wraps 0xFFFF -> 0x0000.

## Operation
- Frame on CMD_o: start bit (1), CMD_WIDTH data bits MSB first, parity bit (if enabled), stop bit (0), then GAP_CYCLES low cycles. Idle line level is 0.
- Every bit, including start and stop, is held exactly CLKS_PER_BIT cycles.
- Acceptance: rising edge where cmd_valid_i && cmd_ready_o. cmd_i is latched into the shift register on that edge. frame_count_o increments on that edge.
- While busy, cmd_valid_i and cmd_i are ignored. No queueing.
- FSM states and transitions:
  - IDLE: on acceptance, go to START.
  - START: after CLKS_PER_BIT cycles, go to DATA.
  - DATA: after CMD_WIDTH bits, go to PARITY (or STOP when parity is compiled out).
  - PARITY: after one bit, go to STOP.
  - STOP: after one bit, go to GAP (or IDLE when GAP_CYCLES = 0).
  - GAP: after GAP_CYCLES cycles, go to IDLE.
- Parity is odd over the data bits: parity bit = ~^data, so the count of ones in data + parity is odd.
- Bit-period counter is ceil(log2(CLKS_PER_BIT+1)) bits wide. Data-bit index counts CMD_WIDTH-1 down to 0.

## Timing
- Reset values: CMD_o = 0, cmd_ready_o = 1, busy_o = 0, frame_count_o = 0x0000, FSM = IDLE.
- Reset mid-frame: CMD_o drops to 0 asynchronously and the frame is aborted, not completed. The counter clears and the latched word is discarded.
- Accept edge k: CMD_o = 1 and cmd_ready_o = 0 starting the cycle after edge k.
- Start bit occupies cycles k+1 .. k+CLKS_PER_BIT. Data bit n (MSB = 0) starts at k+1+(n+1)*CLKS_PER_BIT.
- cmd_ready_o stays low for exactly FRAME_CYCLES = (CMD_WIDTH + 2 + P)*CLKS_PER_BIT + GAP_CYCLES cycles, where P = 1 with parity and 0 without. It is high again in cycle k+FRAME_CYCLES+1.
- Back-to-back: with cmd_valid_i held high, consecutive start bits are FRAME_CYCLES + 1 cycles apart.
- Defaults: FRAME_CYCLES = 48 with parity, 44 without.

## Configuration
- Macro: SURF_CMD_TX_PARITY_EN.
- Defined: the PARITY state is present and one odd-parity bit is sent between the data and stop bits.
- Undefined: the PARITY state is removed, DATA goes directly to STOP, and P = 0 in all timing formulas.
- The receiver side must be built with a matching setting.

## Test plan
All scenarios use default parameters with SURF_CMD_TX_PARITY_EN defined.
- Reset: assert rst_i mid-cycle -> CMD_o = 0, cmd_ready_o = 1, frame_count_o = 0 without waiting for a clock edge.
- Send 0xA5 -> CMD_o line bits 1,1,0,1,0,0,1,0,1,1,0, each 4 cycles wide. This is 44 cycles, then 4 low gap cycles. cmd_ready_o returns high 48 cycles after acceptance. frame_count_o = 1.
- Parity checks:
  - 0x01 -> parity bit 0.
  - 0x00 -> parity bit 1.
  - 0xFF -> parity bit 1.
- Back-to-back 0x3C then 0xC3 with cmd_valid_i held high -> start bits 49 cycles apart. A value change on cmd_i during the first frame does not corrupt its bits.
- Reset asserted during data bit 3 of 0xA5 -> CMD_o = 0 immediately. After release, the next command 0x5A is sent as a complete frame. frame_count_o = 1.
- Preload to 0xFFFF via 65535 sends (or force) then send one more -> frame_count_o = 0x0000. Rebuild without the macro, send 0xA5 -> 10-bit frame, cmd_ready_o low for 44 cycles.
